alu_sequencer: RTL and testbench

Accumulator-based command sequencer that drives the 8-bit ALU operand and select ports and consumes its Result and NZVC outputs. It owns the accumulator and flag registers. It executes single-step ALU commands and a multi-cycle unsigned 8x8 multiply built from repeated ALU ADDs. It sits between the instruction/control logic (valid/ready command port) and the combinational ALU.

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command port and ALU operand/result bundle between the control logic,
// the accumulator sequencer and the combinational ALU.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic [3:0] alu_nzvc;
    logic [7:0] acc;
    logic [7:0] acc_hi;
    logic [3:0] flags;
    logic       done;

    // Master is the initiator plus the ALU it provides; slave is the sequencer.
    modport master (
        output cmd_valid, cmd_op, cmd_data, alu_result, alu_nzvc,
        input  cmd_ready, alu_a, alu_b, alu_sel, acc, acc_hi, flags, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, alu_result, alu_nzvc,
        output cmd_ready, alu_a, alu_b, alu_sel, acc, acc_hi, flags, done
    );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: single-cycle ALU commands, LOAD/CMP/NOP, and an
// 8-cycle unsigned 8x8 shift-add multiply built from ALU ADDs.
module alu_sequencer #(
    parameter logic [7:0] RESET_ACC = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b010;

    state_t     state;
    logic [3:0] op_q;
    logic [7:0] data_q;
    logic [7:0] acc_q;
    logic [7:0] acc_hi_q;
    logic [3:0] flags_q;
    logic       done_q;
    logic [7:0] p_hi;
    logic [7:0] p_lo;
    logic [7:0] m_q;
    logic [2:0] cnt;

    logic       mul_c;
    logic [7:0] mul_s;
    logic [7:0] mul_hi_nx;
    logic [7:0] mul_lo_nx;

    // ALU operands are a state-selected mux of registers only; nothing from cmd_*.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus.alu_a   = acc_q;
        bus.alu_b   = 8'h00;
        bus.alu_sel = SEL_ADD;
        case (state)
            EXEC: begin
                bus.alu_b   = data_q;
                bus.alu_sel = (op_q == OP_CMP) ? SEL_SUB : op_q[2:0];
            end
            MUL: begin
                bus.alu_a   = p_hi;
                bus.alu_b   = m_q;
            end
            default: ;
        endcase
    end

    // One shift-add step: add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        mul_c = 1'b0;
        mul_s = p_hi;
        if (p_lo[0]) begin
            mul_c = bus.alu_nzvc[0];
            mul_s = bus.alu_result;
        end
    end

    assign mul_hi_nx = {mul_c, mul_s[7:1]};
    assign mul_lo_nx = {mul_s[0], p_lo[7:1]};

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= 4'h0;
            data_q   <= 8'h00;
            acc_q    <= RESET_ACC;
            acc_hi_q <= 8'h00;
            flags_q  <= 4'h0;
            done_q   <= 1'b0;
            p_hi     <= 8'h00;
            p_lo     <= 8'h00;
            m_q      <= 8'h00;
            cnt      <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q   <= bus.cmd_op;
                        data_q <= bus.cmd_data;
                        if (bus.cmd_op == OP_MUL) begin
                            p_hi  <= 8'h00;
                            p_lo  <= acc_q;
                            m_q   <= bus.cmd_data;
                            cnt   <= 3'd0;
                            state <= MUL;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (!op_q[3]) begin
                        acc_q   <= bus.alu_result;
                        flags_q <= bus.alu_nzvc;
                    end else if (op_q == OP_LOAD) begin
                        acc_q    <= data_q;
                        acc_hi_q <= 8'h00;
                        flags_q  <= {data_q[7], data_q == 8'h00, 2'b00};
                    end else if (op_q == OP_CMP) begin
                        flags_q <= bus.alu_nzvc;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                MUL: begin
                    p_hi <= mul_hi_nx;
                    p_lo <= mul_lo_nx;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        acc_hi_q <= mul_hi_nx;
                        acc_q    <= mul_lo_nx;
                        flags_q  <= {mul_hi_nx[7], {mul_hi_nx, mul_lo_nx} == 16'h0000,
                                     1'b0, mul_hi_nx != 8'h00};
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.acc       = acc_q;
    assign bus.acc_hi    = acc_hi_q;
    assign bus.flags     = flags_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural 8-bit ALU closes the loop,
// and each step compares DUT state against hand-computed values.
module tb_alu_sequencer;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_INC = 4'b0001, OP_SUB = 4'b0010,
                           OP_DEC = 4'b0011, OP_AND = 4'b0100, OP_OR  = 4'b0101,
                           OP_XOR = 4'b0110, OP_NOT = 4'b0111, OP_LOAD = 4'b1000,
                           OP_MUL = 4'b1001, OP_CMP = 4'b1010, OP_NOP = 4'b1111;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   accept_cyc = 0;
    int   accept_done_cnt = 0;
    int   last_lat = 0;

    alu_sequencer_if bus ();

    alu_sequencer #(.RESET_ACC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    // Reference ALU: 9-bit arithmetic so bit 8 is carry (ADD/INC) or borrow (SUB/DEC).
    logic [8:0] r9;
    logic       v;
    always_comb begin
        r9 = 9'd0;
        v  = 1'b0;
        case (bus.alu_sel)
            3'b000: begin
                r9 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                v  = (bus.alu_a[7] == bus.alu_b[7]) && (r9[7] != bus.alu_a[7]);
            end
            3'b001: begin
                r9 = {1'b0, bus.alu_a} + 9'd1;
                v  = (bus.alu_a == 8'h7F);
            end
            3'b010: begin
                r9 = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                v  = (bus.alu_a[7] != bus.alu_b[7]) && (r9[7] != bus.alu_a[7]);
            end
            3'b011: begin
                r9 = {1'b0, bus.alu_a} - 9'd1;
                v  = (bus.alu_a == 8'h80);
            end
            3'b100:  r9 = {1'b0, bus.alu_a & bus.alu_b};
            3'b101:  r9 = {1'b0, bus.alu_a | bus.alu_b};
            3'b110:  r9 = {1'b0, bus.alu_a ^ bus.alu_b};
            default: r9 = {1'b0, ~bus.alu_a};
        endcase
        bus.alu_result = r9[7:0];
        bus.alu_nzvc   = {r9[7], r9[7:0] == 8'h00, v, r9[8]};
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] data);
        logic ok;
        ok = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_in_time", {15'd0, ok}, 16'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid   = 1'b0;
        accept_cyc      = cyc;
        accept_done_cnt = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {15'd0, ok}, 16'd1);
        last_lat = cyc - accept_cyc;
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] data);
        issue(op, data);
        wait_done("done_seen");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_acc",   {8'h00, bus.acc},    16'h0000);
        check("rst_acc_hi",{8'h00, bus.acc_hi}, 16'h0000);
        check("rst_flags", {12'h0, bus.flags},  16'h0000);
        check("rst_done",  {15'd0, bus.done},   16'd0);
        check("rst_ready", {15'd0, bus.cmd_ready}, 16'd1);
        check("idle_alu",  {bus.alu_b, 5'd0, bus.alu_sel}, 16'h0000);

        // Signed overflow and carry-out
        run(OP_LOAD, 8'h7F);
        check("load7f_acc", {8'h00, bus.acc}, 16'h007F);
        check("load_lat",   last_lat[15:0],    16'd1);
        run(OP_ADD, 8'h01);
        check("add_acc",   {8'h00, bus.acc},   16'h0080);
        check("add_flags", {12'h0, bus.flags}, 16'h000A);
        check("add_ready", {15'd0, bus.cmd_ready}, 16'd1);
        run(OP_LOAD, 8'hFF);
        check("loadff_flags", {12'h0, bus.flags}, 16'h0008);
        run(OP_INC, 8'h00);
        check("inc_acc",   {8'h00, bus.acc},   16'h0000);
        check("inc_flags", {12'h0, bus.flags}, 16'h0005);

        // Borrow, then compare leaving Acc alone
        run(OP_LOAD, 8'h05);
        run(OP_SUB, 8'h07);
        check("sub_acc",   {8'h00, bus.acc},   16'h00FE);
        check("sub_flags", {12'h0, bus.flags}, 16'h0009);
        run(OP_CMP, 8'hFE);
        check("cmp_acc",   {8'h00, bus.acc},   16'h00FE);
        check("cmp_flags", {12'h0, bus.flags}, 16'h0004);
        run(OP_LOAD, 8'h00);
        run(OP_DEC, 8'h00);
        check("dec_acc",   {8'h00, bus.acc},   16'h00FF);
        check("dec_flags", {12'h0, bus.flags}, 16'h0009);

        // Largest product
        run(OP_LOAD, 8'hFF);
        run(OP_MUL, 8'hFF);
        check("mulff_lat",   last_lat[15:0],        16'd8);
        check("mulff_prod",  {bus.acc_hi, bus.acc}, 16'hFE01);
        check("mulff_flags", {12'h0, bus.flags},    16'h0009);
        repeat (3) @(negedge clk);
        check("mulff_one_done", 16'(done_cnt - accept_done_cnt), 16'd1);
        run(OP_ADD, 8'h10);
        check("add_after_mul_acc",   {8'h00, bus.acc},    16'h0011);
        check("add_after_mul_hi",    {8'h00, bus.acc_hi}, 16'h00FE);
        check("add_after_mul_flags", {12'h0, bus.flags},  16'h0000);
        run(OP_LOAD, 8'h00);
        run(OP_MUL, 8'h37);
        check("mul0_prod",  {bus.acc_hi, bus.acc}, 16'h0000);
        check("mul0_flags", {12'h0, bus.flags},    16'h0004);

        // Valid held through a MUL: next command taken in the Done cycle
        run(OP_LOAD, 8'h03);
        bus.cmd_op    = OP_MUL;
        bus.cmd_data  = 8'h05;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        accept_done_cnt = done_cnt;
        bus.cmd_op   = OP_ADD;
        bus.cmd_data = 8'h02;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mul_busy_ready", {15'd0, bus.cmd_ready}, 16'd0);
        end
        @(negedge clk);
        check("held_mul_done",  {15'd0, bus.done},      16'd1);
        check("held_mul_ready", {15'd0, bus.cmd_ready}, 16'd1);
        check("held_mul_prod",  {bus.acc_hi, bus.acc},  16'h000F);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("held_add_busy", {15'd0, bus.done}, 16'd0);
        @(negedge clk);
        check("held_add_done", {15'd0, bus.done}, 16'd1);
        check("held_add_acc",  {8'h00, bus.acc},  16'h0011);
        repeat (4) @(negedge clk);
        check("held_acc_stable", {8'h00, bus.acc}, 16'h0011);
        check("held_two_dones",  16'(done_cnt - accept_done_cnt), 16'd2);

        // Reset in the middle of a MUL discards the partial product
        run(OP_MUL, 8'h20);
        check("mul_pre_prod",  {bus.acc_hi, bus.acc}, 16'h0220);
        check("mul_pre_flags", {12'h0, bus.flags},    16'h0001);
        issue(OP_MUL, 8'h34);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_acc", {8'h00, bus.acc}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_prod",  {bus.acc_hi, bus.acc}, 16'h0000);
        check("midrst_flags", {12'h0, bus.flags},    16'h0000);
        check("midrst_ready", {15'd0, bus.cmd_ready}, 16'd1);
        accept_done_cnt = done_cnt;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 16'(done_cnt - accept_done_cnt), 16'd0);
        check("midrst_acc_hold", {8'h00, bus.acc}, 16'h0000);

        // Logic ops and NOP
        run(OP_LOAD, 8'hF0);
        run(OP_XOR, 8'hFF);
        check("xor_acc",   {8'h00, bus.acc},    16'h000F);
        check("xor_hi",    {8'h00, bus.acc_hi}, 16'h0000);
        check("xor_flags", {12'h0, bus.flags},  16'h0000);
        run(OP_NOT, 8'h00);
        check("not_acc",   {8'h00, bus.acc},   16'h00F0);
        check("not_flags", {12'h0, bus.flags}, 16'h0008);
        run(OP_NOP, 8'hAA);
        check("nop_acc",   {8'h00, bus.acc},   16'h00F0);
        check("nop_flags", {12'h0, bus.flags}, 16'h0008);
        run(OP_AND, 8'h3C);
        check("and_acc", {8'h00, bus.acc}, 16'h0030);
        run(OP_OR, 8'h0F);
        check("or_acc",   {8'h00, bus.acc},   16'h003F);
        check("or_flags", {12'h0, bus.flags}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
